// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port 64-bit backing memory between instruction fetch
//   (IF) and data load/store (MEM). Only one transaction is outstanding at a
//   time. The data port normally wins, but a streak counter limits how many
//   data grants in a row can pass a waiting fetch.
//
//   Stalls are implied: a requester is stalled while its req is high and it
//   has not yet seen its rvalid pulse.
//
// Optional feature macro: ARB_PERF_EN adds the CNT_W parameter and three
// wrapping performance counters (perf_if_stall_o, perf_dm_stall_o, perf_xact_o).
//
// Ports
//   clk_i, rst_ni            clock; synchronous active-low reset
//   if_req_i/if_addr_i       fetch request, held with its address until if_gnt_o
//   if_gnt_o/if_rvalid_o     fetch accept / data-valid pulses
//   if_rdata_o               32-bit instruction word picked by address bit 2
//   dm_req_i/we/addr/wdata   data request, held until dm_gnt_o
//   dm_gnt_o/dm_rvalid_o     data accept / response pulses
//   dm_rdata_o               64-bit load data
//   mem_req_o/we/addr/wdata  request to memory, stable until mem_gnt_i
//   mem_gnt_i/mem_rvalid_i   memory accept / response
//   mem_rdata_i              memory read data
module mem_port_arbiter #(
  parameter int unsigned MAX_DM_STREAK = 4
`ifdef ARB_PERF_EN
  ,
  parameter int unsigned CNT_W         = 32
`endif
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [63:0] dm_addr_i,
  input  logic [63:0] dm_wdata_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [63:0] dm_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i
`ifdef ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_if_stall_o,
  output logic [CNT_W-1:0] perf_dm_stall_o,
  output logic [CNT_W-1:0] perf_xact_o
`endif
);

  localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(MAX_DM_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ZERO = {STREAK_W{1'b0}};
  localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_dm_q, owner_dm_d;   // 1 = data port owns the transaction
  logic                we_q, we_d;
  logic [63:0]         addr_q, addr_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [63:0]         dm_rdata_q, dm_rdata_d;

  logic                gnt_s;
  logic                rsp_s;
  logic                fetch_wins_s;
  logic [31:0]         if_word_s;

  // Qualify memory handshakes by state (and reset) so stray strobes never reach a requester.
  always_comb begin
    gnt_s        = rst_ni && (state_q == ST_REQ)  && mem_gnt_i;
    rsp_s        = rst_ni && (state_q == ST_WAIT) && mem_rvalid_i;
    fetch_wins_s = !dm_req_i || (if_req_i && (streak_q == STREAK_MAX));
    if (addr_q[2]) begin
      if_word_s = mem_rdata_i[63:32];
    end else begin
      if_word_s = mem_rdata_i[31:0];
    end
  end

  // Next-state logic: arbitration, request latching, streak tracking, response capture.
  always_comb begin
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    streak_d   = streak_q;
    mem_req_d  = mem_req_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (if_req_i || dm_req_i) begin
          state_d    = ST_REQ;
          mem_req_d  = 1'b1;
          owner_dm_d = !fetch_wins_s;
          if (fetch_wins_s) begin
            we_d    = 1'b0;
            addr_d  = if_addr_i;
            wdata_d = 64'd0;
          end else begin
            we_d    = dm_we_i;
            addr_d  = dm_addr_i;
            wdata_d = dm_wdata_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (gnt_s) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b0;
          // Streak only grows while a fetch is actually being passed over.
          if (!owner_dm_q) begin
            streak_d = STREAK_ZERO;
          end else if (!if_req_i) begin
            streak_d = STREAK_ZERO;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_ONE;
          end else begin
            streak_d = streak_q;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (rsp_s) begin
          state_d = ST_IDLE;
          if (owner_dm_q) begin
            dm_rdata_d = mem_rdata_i;
          end else begin
            if_rdata_d = if_word_s;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Arbiter state registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      streak_q   <= STREAK_ZERO;
      mem_req_q  <= 1'b0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 64'd0;
    end else begin
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      streak_q   <= streak_d;
      mem_req_q  <= mem_req_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  // Accept/response pulses coincide with the memory strobe and go to the owner only.
  assign if_gnt_o    = gnt_s && !owner_dm_q;
  assign dm_gnt_o    = gnt_s &&  owner_dm_q;
  assign if_rvalid_o = rsp_s && !owner_dm_q;
  assign dm_rvalid_o = rsp_s &&  owner_dm_q;

  // Read data passes straight through in the response cycle and is held afterwards.
  assign if_rdata_o  = if_rvalid_o ? if_word_s   : if_rdata_q;
  assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : dm_rdata_q;

`ifdef ARB_PERF_EN
  logic [CNT_W-1:0] perf_if_stall_q, perf_if_stall_d;
  logic [CNT_W-1:0] perf_dm_stall_q, perf_dm_stall_d;
  logic [CNT_W-1:0] perf_xact_q, perf_xact_d;

  // Stall counters follow the implied-stall rule; the transaction counter counts accepted requests.
  always_comb begin
    if (if_req_i && !if_rvalid_o) begin
      perf_if_stall_d = perf_if_stall_q + CNT_W'(1);
    end else begin
      perf_if_stall_d = perf_if_stall_q;
    end
    if (dm_req_i && !dm_rvalid_o) begin
      perf_dm_stall_d = perf_dm_stall_q + CNT_W'(1);
    end else begin
      perf_dm_stall_d = perf_dm_stall_q;
    end
    if (gnt_s) begin
      perf_xact_d = perf_xact_q + CNT_W'(1);
    end else begin
      perf_xact_d = perf_xact_q;
    end
  end

  // Performance counter registers; they wrap naturally at 2^CNT_W.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_if_stall_q <= {CNT_W{1'b0}};
      perf_dm_stall_q <= {CNT_W{1'b0}};
      perf_xact_q     <= {CNT_W{1'b0}};
    end else begin
      perf_if_stall_q <= perf_if_stall_d;
      perf_dm_stall_q <= perf_dm_stall_d;
      perf_xact_q     <= perf_xact_d;
    end
  end

  assign perf_if_stall_o = perf_if_stall_q;
  assign perf_dm_stall_o = perf_dm_stall_q;
  assign perf_xact_o     = perf_xact_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter: each task drives one scenario and
//   compares DUT outputs against hand-computed values. Inputs change 1ns after
//   the rising edge and outputs are sampled 3ns after the edge.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i;
  logic [63:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [63:0] dm_addr_i;
  logic [63:0] dm_wdata_i;
  logic        dm_gnt_o;
  logic        dm_rvalid_o;
  logic [63:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;
`ifdef ARB_PERF_EN
  logic [31:0] perf_if_stall_o;
  logic [31:0] perf_dm_stall_o;
  logic [31:0] perf_xact_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef ARB_PERF_EN
    ,
    .perf_if_stall_o(perf_if_stall_o), .perf_dm_stall_o(perf_dm_stall_o), .perf_xact_o(perf_xact_o)
`endif
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic zero_inputs();
    if_req_i = 1'b0; if_addr_i = 64'd0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 64'd0; dm_wdata_i = 64'd0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'd0;
  endtask

  // Release both requesters and let any open transaction finish.
  task automatic drain();
    if_req_i = 1'b0; dm_req_i = 1'b0;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    repeat (3) step();
    zero_inputs();
    step();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    zero_inputs();
    step(); step(); settle();
    checks++; if ({if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_req_o, mem_we_o} !== 6'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 000000", {if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_req_o, mem_we_o}); end
    checks++; if (if_rdata_o !== 32'd0) begin errors++; $display("FAIL reset_if_rdata: got %h expected 0", if_rdata_o); end
    checks++; if (dm_rdata_o !== 64'd0) begin errors++; $display("FAIL reset_dm_rdata: got %h expected 0", dm_rdata_o); end
    checks++; if ({mem_addr_o, mem_wdata_o} !== 128'd0) begin errors++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_addr_o, mem_wdata_o}); end
    rst_ni = 1'b1;
    step();
  endtask

`ifdef ARB_PERF_EN
  // Fetch stalled 5 cycles (c0..c4) before its rvalid in c5.
  task automatic test_perf();
    if_req_i = 1'b1; if_addr_i = 64'h10;
    settle();
    checks++; if ({perf_if_stall_o, perf_dm_stall_o, perf_xact_o} !== 96'd0) begin errors++; $display("FAIL perf_reset: got %h expected 0", {perf_if_stall_o, perf_dm_stall_o, perf_xact_o}); end
    step(); mem_gnt_i = 1'b0;
    step(); mem_gnt_i = 1'b1; settle();
    checks++; if (if_gnt_o !== 1'b1) begin errors++; $display("FAIL perf_gnt: got %b expected 1", if_gnt_o); end
    step(); mem_gnt_i = 1'b0;
    step();
    step(); mem_rvalid_i = 1'b1; mem_rdata_i = 64'h5;
    settle();
    checks++; if (if_rvalid_o !== 1'b1) begin errors++; $display("FAIL perf_rvalid: got %b expected 1", if_rvalid_o); end
    step(); zero_inputs(); settle();
    checks++; if (perf_if_stall_o !== 32'd5) begin errors++; $display("FAIL perf_if_stall: got %0d expected 5", perf_if_stall_o); end
    checks++; if (perf_xact_o !== 32'd1) begin errors++; $display("FAIL perf_xact: got %0d expected 1", perf_xact_o); end
    checks++; if (perf_dm_stall_o !== 32'd0) begin errors++; $display("FAIL perf_dm_stall: got %0d expected 0", perf_dm_stall_o); end
    step();
  endtask
`endif

  task automatic test_fetch();
    // Lower word (addr bit 2 = 0), minimum latency.
    if_req_i = 1'b1; if_addr_i = 64'h8;
    settle();
    checks++; if ({if_gnt_o, mem_req_o} !== 2'b00) begin errors++; $display("FAIL fetch_c0: got %b expected 00", {if_gnt_o, mem_req_o}); end
    step(); mem_gnt_i = 1'b1; settle();
    checks++; if ({mem_req_o, mem_we_o, if_gnt_o, dm_gnt_o} !== 4'b1010) begin errors++; $display("FAIL fetch_c1_strobes: got %b expected 1010", {mem_req_o, mem_we_o, if_gnt_o, dm_gnt_o}); end
    checks++; if (mem_addr_o !== 64'h8) begin errors++; $display("FAIL fetch_addr: got %h expected 8", mem_addr_o); end
    step(); if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hAAAA_BBBB_1111_2222; settle();
    checks++; if ({if_rvalid_o, dm_rvalid_o} !== 2'b10) begin errors++; $display("FAIL fetch_c2_rvalid: got %b expected 10", {if_rvalid_o, dm_rvalid_o}); end
    checks++; if (if_rdata_o !== 32'h1111_2222) begin errors++; $display("FAIL fetch_rdata_lo: got %h expected 11112222", if_rdata_o); end
    step(); mem_rvalid_i = 1'b0; mem_rdata_i = 64'd0; settle();
    checks++; if ({if_rvalid_o, mem_req_o} !== 2'b00) begin errors++; $display("FAIL fetch_c3: got %b expected 00", {if_rvalid_o, mem_req_o}); end
    checks++; if (if_rdata_o !== 32'h1111_2222) begin errors++; $display("FAIL fetch_rdata_hold: got %h expected 11112222", if_rdata_o); end
    // Upper word (addr bit 2 = 1).
    step(); if_req_i = 1'b1; if_addr_i = 64'hC;
    step(); mem_gnt_i = 1'b1;
    step(); if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hAAAA_BBBB_1111_2222; settle();
    checks++; if (if_rdata_o !== 32'hAAAA_BBBB) begin errors++; $display("FAIL fetch_rdata_hi: got %h expected aaaabbbb", if_rdata_o); end
    step(); zero_inputs(); step();
  endtask

  task automatic test_store();
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 64'h40; dm_wdata_i = 64'h1234;
    step();
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 64'h40, 64'h1234}) begin errors++; $display("FAIL store_hold%0d: got %b %b %h %h expected 1 1 40 1234", i, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o); end
      checks++; if (dm_gnt_o !== 1'b0) begin errors++; $display("FAIL store_early_gnt%0d: got %b expected 0", i, dm_gnt_o); end
      step();
    end
    mem_gnt_i = 1'b1; settle();
    checks++; if ({dm_gnt_o, if_gnt_o} !== 2'b10) begin errors++; $display("FAIL store_gnt: got %b expected 10", {dm_gnt_o, if_gnt_o}); end
    step(); dm_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; settle();
    checks++; if ({dm_rvalid_o, if_rvalid_o} !== 2'b10) begin errors++; $display("FAIL store_ack: got %b expected 10", {dm_rvalid_o, if_rvalid_o}); end
    step(); zero_inputs(); step();
  endtask

  task automatic test_spurious();
    // Strobes in IDLE with no requests.
    mem_rvalid_i = 1'b1; mem_gnt_i = 1'b1; settle();
    checks++; if ({if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o} !== 4'b0) begin errors++; $display("FAIL spur_idle: got %b expected 0000", {if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o}); end
    step(); mem_gnt_i = 1'b0; settle();
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL spur_idle_state: got %b expected 0", mem_req_o); end
    // Load request dropped before its grant; rvalid held high through REQ.
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 64'h80;
    step(); dm_req_i = 1'b0; settle();
    checks++; if ({mem_req_o, if_rvalid_o, dm_rvalid_o} !== 3'b100) begin errors++; $display("FAIL spur_req1: got %b expected 100", {mem_req_o, if_rvalid_o, dm_rvalid_o}); end
    step(); settle();
    checks++; if ({mem_req_o, if_rvalid_o, dm_rvalid_o} !== 3'b100) begin errors++; $display("FAIL spur_req2: got %b expected 100", {mem_req_o, if_rvalid_o, dm_rvalid_o}); end
    checks++; if (mem_addr_o !== 64'h80) begin errors++; $display("FAIL spur_addr: got %h expected 80", mem_addr_o); end
    step(); mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1; settle();
    checks++; if (dm_gnt_o !== 1'b1) begin errors++; $display("FAIL spur_dropped_gnt: got %b expected 1", dm_gnt_o); end
    // Stray grant while waiting for the response.
    step(); settle();
    checks++; if ({if_gnt_o, dm_gnt_o} !== 2'b00) begin errors++; $display("FAIL spur_wait_gnt: got %b expected 00", {if_gnt_o, dm_gnt_o}); end
    step(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h0123_4567_89AB_CDEF; settle();
    checks++; if ({dm_rvalid_o, dm_rdata_o} !== {1'b1, 64'h0123_4567_89AB_CDEF}) begin errors++; $display("FAIL spur_load: got %b %h expected 1 0123456789abcdef", dm_rvalid_o, dm_rdata_o); end
    step(); zero_inputs(); settle();
    checks++; if (dm_rdata_o !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL spur_load_hold: got %h expected 0123456789abcdef", dm_rdata_o); end
    step();
  endtask

  // Both ports hold requests; collect n grants and compare against the expected owner order.
  task automatic run_contention(input string tag, input int n, input logic [9:0] exp_dm);
    logic [9:0] got_dm;
    int got;
    int both;
    got = 0; both = 0; got_dm = 10'd0;
    if_req_i = 1'b1; if_addr_i = 64'h100;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 64'h200;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
      settle();
      if (if_gnt_o && dm_gnt_o) begin
        both++;
      end else if (dm_gnt_o || if_gnt_o) begin
        got_dm[got] = dm_gnt_o;
        checks++; if (mem_addr_o !== (dm_gnt_o ? 64'h200 : 64'h100)) begin errors++; $display("FAIL %s_addr%0d: got %h expected %h", tag, got, mem_addr_o, dm_gnt_o ? 64'h200 : 64'h100); end
        got++;
      end
      step();
    end
    checks++; if (got != n) begin errors++; $display("FAIL %s_timeout: got %0d grants expected %0d", tag, got, n); end
    checks++; if (both != 0) begin errors++; $display("FAIL %s_double_gnt: got %0d cycles expected 0", tag, both); end
    for (int i = 0; i < n; i++) begin
      checks++; if (got_dm[i] !== exp_dm[i]) begin errors++; $display("FAIL %s_order%0d: got dm=%b expected dm=%b", tag, i, got_dm[i], exp_dm[i]); end
    end
    drain();
  endtask

  task automatic test_contention();
    // Owner order D,D,D,D,I,D,D,D,D,I (bit i = grant i, 1 = data).
    run_contention("contention", 10, 10'b0111101111);
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_req;
    logic [4:0] exp_gnt;
    logic [4:0] exp_rv;
    exp_req = 5'b10010; exp_gnt = 5'b10010; exp_rv = 5'b00100;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 64'h300;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hFEED_0000_0000_1111;
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++; if ({mem_req_o, dm_gnt_o, dm_rvalid_o} !== {exp_req[c], exp_gnt[c], exp_rv[c]}) begin errors++; $display("FAIL b2b_c%0d: got %b expected %b", c, {mem_req_o, dm_gnt_o, dm_rvalid_o}, {exp_req[c], exp_gnt[c], exp_rv[c]}); end
      if (c == 2) begin
        checks++; if (dm_rdata_o !== 64'hFEED_0000_0000_1111) begin errors++; $display("FAIL b2b_rdata: got %h expected feed000000001111", dm_rdata_o); end
      end
      step();
    end
    drain();
  endtask

  task automatic test_reset_wait();
    int cnt;
    cnt = 0;
    // Build a data streak of 3 with fetch pending.
    if_req_i = 1'b1; if_addr_i = 64'h100;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 64'h200;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int cyc = 0; cyc < 40 && cnt < 3; cyc++) begin
      settle();
      if (dm_gnt_o) cnt++;
      step();
    end
    checks++; if (cnt != 3) begin errors++; $display("FAIL rstw_setup: got %0d grants expected 3", cnt); end
    // Now in WAIT: reset for one cycle.
    rst_ni = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    step(); rst_ni = 1'b1; mem_rvalid_i = 1'b1; mem_gnt_i = 1'b1; settle();
    checks++; if ({if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_req_o, mem_we_o} !== 6'b0) begin errors++; $display("FAIL rstw_strobes: got %b expected 000000", {if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_req_o, mem_we_o}); end
    checks++; if ({if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o} !== 224'd0) begin errors++; $display("FAIL rstw_data: got %h expected 0", {if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o}); end
    step(); settle();
    checks++; if ({if_rvalid_o, dm_rvalid_o} !== 2'b00) begin errors++; $display("FAIL rstw_late_rvalid: got %b expected 00", {if_rvalid_o, dm_rvalid_o}); end
    step(); zero_inputs(); step();
    // A cleared streak gives four data grants before fetch wins.
    run_contention("rstw_streak", 5, 10'b0000001111);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
`ifdef ARB_PERF_EN
    test_perf();
`endif
    test_fetch();
    test_store();
    test_spurious();
    test_contention();
    test_back_to_back();
    test_reset_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
